vec_load_writeback_unit: RTL and testbench

- Return-path counterpart of the vector memory address generator.
- Accepts memory read-response beats for a unit-stride vector load and writes them into the vector register file.
- Walks register address and in-register offset in the same order the request side issued them.
- Applies the tail byte mask on the final beat and signals completion to the issue logic.

---
 rtl/vec_load_writeback_unit.sv | 139 +++++++++++++
 tb/tb_vec_load_writeback_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vec_load_writeback_unit.sv
// Writes unit-stride vector load response beats into the vector register file,
// walking register/word offset in issue order and masking the tail of the last beat.
module vec_load_writeback_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int DW_B       = 8,
    parameter int DW_B_BITS  = 3,
    parameter int WPR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vd_base,
    input  logic [OFF_WIDTH-1:0]  num_beats,
    input  logic [DW_B_BITS-1:0]  tail_bytes,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rready,
    output logic                  vr_we,
    output logic [ADDR_WIDTH-1:0] vr_waddr,
    output logic [WPR_BITS-1:0]   vr_woff,
    output logic [DATA_WIDTH-1:0] vr_wdata,
    output logic [DW_B-1:0]       vr_wbe,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [OFF_WIDTH-1:0]  beat_q, beat_d;
    logic [OFF_WIDTH-1:0]  num_q, num_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DW_B_BITS-1:0]  tail_q, tail_d;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WPR_BITS-1:0]   woff_q, woff_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DW_B-1:0]       wbe_q, wbe_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  last_beat;
    logic [DW_B-1:0]       tail_mask;

    assign accept    = (state_q == S_BUSY) && mem_rvalid;
    assign last_beat = (beat_q == (num_q - OFF_WIDTH'(1)));
    assign tail_mask = (DW_B'(1) << tail_q) - DW_B'(1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        num_d   = num_q;
        base_d  = base_q;
        tail_d  = tail_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        woff_d  = woff_q;
        wdata_d = wdata_q;
        wbe_d   = wbe_q;
        // done trails the DONE state by one cycle so it never overlaps the final write
        done_d  = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_beats != '0) begin
                        base_d  = vd_base;
                        num_d   = num_beats;
                        tail_d  = tail_bytes;
                        beat_d  = '0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = base_q + ADDR_WIDTH'(beat_q >> WPR_BITS);
                    woff_d  = beat_q[WPR_BITS-1:0];
                    wdata_d = mem_rdata;
                    wbe_d   = (last_beat && (tail_q != '0)) ? tail_mask : '1;
                    beat_d  = beat_q + OFF_WIDTH'(1);
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            num_q   <= '0;
            base_q  <= '0;
            tail_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            woff_q  <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            num_q   <= num_d;
            base_q  <= base_d;
            tail_q  <= tail_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            woff_q  <= woff_d;
            wdata_q <= wdata_d;
            wbe_q   <= wbe_d;
            done_q  <= done_d;
        end
    end

    assign mem_rready = (state_q == S_BUSY);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign vr_we      = we_q;
    assign vr_waddr   = waddr_q;
    assign vr_woff    = woff_q;
    assign vr_wdata   = wdata_q;
    assign vr_wbe     = wbe_q;

endmodule

// File: tb/tb_vec_load_writeback_unit.sv
// Directed bench for vec_load_writeback_unit with hand-computed expectations.
module tb_vec_load_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  vd_base;
    logic [7:0]  num_beats;
    logic [2:0]  tail_bytes;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rready;
    logic        vr_we;
    logic [4:0]  vr_waddr;
    logic [1:0]  vr_woff;
    logic [63:0] vr_wdata;
    logic [7:0]  vr_wbe;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_load_writeback_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vd_base(vd_base),
        .num_beats(num_beats), .tail_bytes(tail_bytes),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .vr_we(vr_we), .vr_waddr(vr_waddr), .vr_woff(vr_woff),
        .vr_wdata(vr_wdata), .vr_wbe(vr_wbe), .busy(busy), .done(done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [4:0] a, input logic [1:0] o,
                             input logic [63:0] d, input logic [7:0] be);
        chk({tag, ".we"}, 64'(vr_we), 64'd1);
        chk({tag, ".waddr"}, 64'(vr_waddr), 64'(a));
        chk({tag, ".woff"}, 64'(vr_woff), 64'(o));
        chk({tag, ".wdata"}, vr_wdata, d);
        chk({tag, ".wbe"}, 64'(vr_wbe), 64'(be));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".we"}, 64'(vr_we), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".rready"}, 64'(mem_rready), 64'd0);
    endtask

    logic [4:0] exp_a6[6];
    logic [1:0] exp_o6[6];
    logic [4:0] exp_a8[8];
    logic [1:0] exp_o8[8];

    initial begin
        rst_n = 1'b0; start = 1'b0; vd_base = '0; num_beats = '0; tail_bytes = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        chk_idle("reset");
        chk("reset.waddr", 64'(vr_waddr), 64'd0);
        chk("reset.woff", 64'(vr_woff), 64'd0);
        chk("reset.wdata", vr_wdata, 64'd0);
        chk("reset.wbe", 64'(vr_wbe), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Test 1: base 4, 6 beats, continuous valid, full masks
        exp_a6 = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd5, 5'd5};
        exp_o6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        start = 1'b1; vd_base = 5'd4; num_beats = 8'd6; tail_bytes = 3'd0;
        cyc();
        start = 1'b0;
        chk("t1.busy", 64'(busy), 64'd1);
        chk("t1.rready", 64'(mem_rready), 64'd1);
        chk("t1.we0", 64'(vr_we), 64'd0);
        for (int i = 0; i < 6; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'h10 + 64'(i);
            cyc();
            chk_write($sformatf("t1.w%0d", i), exp_a6[i], exp_o6[i], 64'h10 + 64'(i), 8'hFF);
            chk($sformatf("t1.done_w%0d", i), 64'(done), 64'd0);
        end
        mem_rvalid = 1'b0;
        chk("t1.busy_last", 64'(busy), 64'd1);
        chk("t1.rready_done", 64'(mem_rready), 64'd0);
        cyc();
        chk("t1.done", 64'(done), 64'd1);
        chk("t1.we_after", 64'(vr_we), 64'd0);
        chk("t1.busy_after", 64'(busy), 64'd0);
        cyc();
        chk("t1.done_once", 64'(done), 64'd0);

        // Test 2: 3 beats, tail 5, valid toggling
        start = 1'b1; vd_base = 5'd2; num_beats = 8'd3; tail_bytes = 3'd5;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_0000_0000_0000 + 64'(i);
            cyc();
            chk_write($sformatf("t2.w%0d", i), 5'd2, 2'(i), 64'hCAFE_0000_0000_0000 + 64'(i),
                      (i == 2) ? 8'h1F : 8'hFF);
            mem_rvalid = 1'b0;
            cyc();
            chk($sformatf("t2.gap%0d", i), 64'(vr_we), 64'd0);
            chk($sformatf("t2.hold%0d", i), 64'(vr_woff), 64'(i));
        end
        chk("t2.done", 64'(done), 64'd1);
        cyc();

        // Test 3: base 31 wraps to register 0
        exp_a8 = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0};
        exp_o8 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        start = 1'b1; vd_base = 5'd31; num_beats = 8'd8; tail_bytes = 3'd0;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hA000 + 64'(i);
            cyc();
            chk_write($sformatf("t3.w%0d", i), exp_a8[i], exp_o8[i], 64'hA000 + 64'(i), 8'hFF);
        end
        mem_rvalid = 1'b0;
        cyc();
        chk("t3.done", 64'(done), 64'd1);
        cyc();

        // Test 4: zero beats
        start = 1'b1; vd_base = 5'd9; num_beats = 8'd0; tail_bytes = 3'd0;
        cyc();
        start = 1'b0;
        chk("t4.busy", 64'(busy), 64'd1);
        chk("t4.we", 64'(vr_we), 64'd0);
        chk("t4.done_early", 64'(done), 64'd0);
        chk("t4.rready", 64'(mem_rready), 64'd0);
        cyc();
        chk("t4.done", 64'(done), 64'd1);
        chk("t4.busy_after", 64'(busy), 64'd0);
        chk("t4.we_after", 64'(vr_we), 64'd0);
        cyc();

        // Test 5: start while busy is ignored
        exp_a6 = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd11, 5'd11};
        start = 1'b1; vd_base = 5'd10; num_beats = 8'd6; tail_bytes = 3'd3;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'h5500 + 64'(i);
            if (i == 2) begin
                start = 1'b1; vd_base = 5'd20; num_beats = 8'd2; tail_bytes = 3'd1;
            end
            cyc();
            start = 1'b0;
            chk_write($sformatf("t5.w%0d", i), exp_a6[i], exp_o6[i], 64'h5500 + 64'(i),
                      (i == 5) ? 8'h07 : 8'hFF);
        end
        mem_rvalid = 1'b0;
        cyc();
        chk("t5.done", 64'(done), 64'd1);
        cyc();

        // Test 6: reset mid-transfer aborts
        start = 1'b1; vd_base = 5'd7; num_beats = 8'd6; tail_bytes = 3'd0;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'h7700 + 64'(i);
            cyc();
            chk_write($sformatf("t6.w%0d", i), 5'd7, 2'(i), 64'h7700 + 64'(i), 8'hFF);
        end
        rst_n = 1'b0;
        cyc();
        chk_idle("t6.rst");
        chk("t6.rst.waddr", 64'(vr_waddr), 64'd0);
        chk("t6.rst.wdata", vr_wdata, 64'd0);
        chk("t6.rst.wbe", 64'(vr_wbe), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
            cyc();
            chk_idle($sformatf("t6.post%0d", i));
        end
        mem_rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
